// File: rtl/spi_slave_rx_tx_if.sv
// SPI slave bus bundle: serial pins plus the RAM-side word ports.
// The slave modport is the front end; the master modport drives it.
interface spi_slave_rx_tx_if #(
    parameter int RX_WIDTH = 10,
    parameter int TX_WIDTH = 8
);
    logic                ss_n;
    logic                mosi;
    logic                miso;
    logic [RX_WIDTH-1:0] rx_data;
    logic                rx_valid;
    logic [TX_WIDTH-1:0] tx_data;
    logic                tx_valid;

    modport slave (
        input  ss_n,
        input  mosi,
        input  tx_data,
        input  tx_valid,
        output miso,
        output rx_data,
        output rx_valid
    );

    modport master (
        output ss_n,
        output mosi,
        output tx_data,
        output tx_valid,
        input  miso,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI slave front end for the single-port SPI RAM.
// Deserialises MOSI into RAM words and serialises read data onto MISO.
module spi_slave_rx_tx #(
    parameter int RX_WIDTH = 10,
    parameter int TX_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    spi_slave_rx_tx_if.slave bus
);
    localparam int TCW = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;
    localparam logic [3:0]     RX_LAST = 4'(RX_WIDTH - 1);
    localparam logic [TCW-1:0] TX_LAST = TCW'(TX_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]          bit_cnt;
    logic [RX_WIDTH-2:0] rx_shift;
    logic                rx_done;
    logic [TX_WIDTH-1:0] tx_shift;
    logic [TCW-1:0]      tx_cnt;
    logic                tx_busy;
    logic                tx_sent;
    logic                rd_addr_done;

    logic shift_en;
    logic word_done;
    logic tx_load;
    logic tx_step;
    logic tx_last;
    logic leave;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge control strobes.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        word_done = 1'b0;
        tx_load   = 1'b0;
        tx_step   = 1'b0;
        tx_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.ss_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.ss_n) begin
                    state_nxt = IDLE;
                end else if (!bus.mosi) begin
                    state_nxt = WRITE;
                end else if (!rd_addr_done) begin
                    state_nxt = READ_ADD;
                end else begin
                    state_nxt = READ_DATA;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                // A word whose last bit lands with ss_n rising still completes.
                if (!rx_done) begin
                    shift_en = 1'b1;
                    if (bit_cnt == RX_LAST) begin
                        word_done = 1'b1;
                    end
                end else if (state == READ_DATA) begin
                    if (tx_busy) begin
                        tx_step = 1'b1;
                        if (tx_cnt == TX_LAST) begin
                            tx_last = 1'b1;
                        end
                    end else if (!tx_sent && bus.tx_valid && !bus.ss_n) begin
                        tx_load = 1'b1;
                    end
                end
                if (bus.ss_n) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign leave = (state != IDLE) && (state_nxt == IDLE);

    // Receive path: shift MOSI in and publish the finished word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_done      <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (word_done) begin
                bus.rx_data  <= {rx_shift, bus.mosi};
                bus.rx_valid <= 1'b1;
            end
            if (leave) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                rx_done  <= 1'b0;
            end else if (shift_en) begin
                rx_shift <= {rx_shift[RX_WIDTH-3:0], bus.mosi};
                bit_cnt  <= bit_cnt + 4'd1;
                if (word_done) begin
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Transmit path: capture RAM data and walk it out MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_sent  <= 1'b0;
        end else if (leave) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_sent  <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= bus.tx_data;
            tx_cnt   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_step) begin
            if (tx_last) begin
                tx_shift <= '0;
                tx_busy  <= 1'b0;
                tx_sent  <= 1'b1;
            end else begin
                tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
                tx_cnt   <= tx_cnt + 1'b1;
            end
        end
    end

    // Read-address flag: set by a finished address frame, cleared after transmit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_done <= 1'b0;
        end else if (tx_last) begin
            rd_addr_done <= 1'b0;
        end else if (word_done && state == READ_ADD) begin
            rd_addr_done <= 1'b1;
        end
    end

    assign bus.miso = tx_busy & tx_shift[TX_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Scoreboard bench for spi_slave_rx_tx: directed frames push expected
// words and MISO bits; a monitor pops and compares after each edge.
module tb_spi_slave_rx_tx;
    logic clk = 1'b0;
    logic rst;

    spi_slave_rx_tx_if #(.RX_WIDTH(10), .TX_WIDTH(8)) bus ();

    spi_slave_rx_tx #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [9:0] rxq[$];
    logic       mq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare outputs just after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (bus.rx_valid) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected no strobe",
                             bus.rx_data);
                end else begin
                    check("rx_data", 32'(bus.rx_data), 32'(rxq.pop_front()));
                end
            end
            if (mq.size() != 0) begin
                check("miso_bit", 32'(bus.miso), 32'(mq.pop_front()));
            end else begin
                check("miso_idle", 32'(bus.miso), 32'd0);
            end
        end
    end

    // One frame: command bit, nbits data bits MSB first, optional close.
    task automatic frame(input logic c, input logic [9:0] w, input int nbits,
                         input bit close, input bit early);
        if (nbits == 10) rxq.push_back(w);
        @(negedge clk);
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        @(negedge clk);
        bus.mosi = c;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.mosi = w[9-i];
            if (early && i == nbits - 1) bus.ss_n = 1'b1;
        end
        if (close && !early) begin
            @(negedge clk);
            bus.ss_n = 1'b1;
            bus.mosi = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx_pat;
        rst = 1'b1;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        rst = 1'b0;

        frame(1'b0, 10'h055, 10, 1'b1, 1'b0);
        check("wr_addr_rd_flag", 32'(dut.rd_addr_done), 32'd0);

        fork
            frame(1'b0, 10'h1AA, 10, 1'b1, 1'b0);
            begin
                repeat (5) @(negedge clk);
                bus.tx_data = 8'hFF;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                bus.tx_data = '0;
            end
        join

        frame(1'b0, 10'h2F0, 10, 1'b0, 1'b1);
        @(negedge clk);
        check("early_ss_state", 32'(dut.state), 32'd0);

        frame(1'b1, 10'h203, 5, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_state", 32'(dut.state), 32'd0);
        check("abort_rd_flag", 32'(dut.rd_addr_done), 32'd0);

        frame(1'b1, 10'h203, 10, 1'b1, 1'b0);
        check("rd_addr_flag_set", 32'(dut.rd_addr_done), 32'd1);

        frame(1'b1, 10'h300, 10, 1'b0, 1'b0);
        @(negedge clk);
        tx_pat = 8'hC3;
        bus.tx_data = tx_pat;
        bus.tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) mq.push_back(tx_pat[i]);
        mq.push_back(1'b0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        repeat (8) @(negedge clk);
        check("rd_data_flag_clr", 32'(dut.rd_addr_done), 32'd0);
        bus.ss_n = 1'b1;

        frame(1'b1, 10'h203, 10, 1'b1, 1'b0);
        frame(1'b1, 10'h000, 4, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_miso", 32'(bus.miso), 32'd0);
        check("midrst_rd_flag", 32'(dut.rd_addr_done), 32'd0);
        check("midrst_state", 32'(dut.state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_chk_cmd", 32'(dut.state), 32'd1);
        @(negedge clk);
        bus.ss_n = 1'b1;
        repeat (3) @(negedge clk);

        check("rx_queue_empty", 32'(rxq.size()), 32'd0);
        check("miso_queue_empty", 32'(mq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

SPI slave front end that sits directly upstream of the single-port SPI RAM. It deserialises MOSI frames into 10-bit command/data words (`rx_data`, `rx_valid`) for the RAM. It serialises the RAM's 8-bit read data (`tx_data`, `tx_valid`) back onto MISO. It also tracks whether a read address has been loaded, so that read commands alternate between the address phase and the data phase.

## Interface
- `RX_WIDTH`, default 10: width of the word sent to the RAM (2-bit opcode plus 8-bit payload).
- `TX_WIDTH`, default 8: width of the read data returned by the RAM.

Ports (clock and reset first):
- `clk`, input, 1: single clock. It is also the SPI clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `ss_n`, input, 1: slave select, active low. Frames are delimited by it.
- `mosi`, input, 1: serial data in, sampled on the rising edge of `clk`, MSB first.
- `miso`, output, 1: serial data out, MSB first.
- `rx_data`, output, RX_WIDTH: assembled word for the RAM `din`.
- `rx_valid`, output, 1: one-cycle strobe qualifying `rx_data`.
- `tx_data`, input, TX_WIDTH: read data from the RAM `dout`.
- `tx_valid`, input, 1: qualifies `tx_data`.

## Operation
- The FSM has five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. There is an internal flag `rd_addr_done` and a 4-bit bit counter.
- **IDLE**
  - `ss_n=0` moves to CHK_CMD.
  - Otherwise the FSM stays in IDLE.
- **CHK_CMD**: the FSM samples `mosi` as the command bit `c`.
  - `ss_n=1` moves to IDLE.
  - `c=0` moves to WRITE.
  - `c=1` with `rd_addr_done=0` moves to READ_ADD.
  - `c=1` with `rd_addr_done=1` moves to READ_DATA.
- **WRITE, READ_ADD, READ_DATA, receive phase**
  - The next RX_WIDTH `mosi` bits shift MSB first into a shift register.
  - On the edge that samples bit 0, `rx_data` is loaded with the full word and `rx_valid` goes high for exactly one cycle.
  - Further `mosi` bits in the same frame are ignored.
- **READ_ADD completion**: sets `rd_addr_done=1`.
- **READ_DATA, after `rx_valid`**
  - The FSM waits for `tx_valid=1` and captures `tx_data` into a TX shift register.
  - It then drives TX_WIDTH bits on `miso`, MSB first, one per cycle.
  - After the last bit it clears `rd_addr_done`, and `miso` returns to 0.
- The opcode bits in `rx_data[9:8]` are passed through unchecked. The frame type follows the CHK_CMD bit only.
- In any non-IDLE state, `ss_n=1` moves to IDLE on the next edge.
  - The counter and shift registers are cleared.
  - No `rx_valid` is issued for a partial word.
  - `rd_addr_done` keeps its value unless the READ_DATA transmit phase completed.
- `tx_valid` is ignored outside the READ_DATA wait phase.
- A `tx_valid` that is already high at the moment the wait phase begins is accepted immediately.

## Timing
- **Reset values**: state=IDLE, `rd_addr_done=0`, `rx_data=0`, `rx_valid=0`, `miso=0`, counter=0.
- **Reset mid-frame**: the asynchronous reset forces all reset values immediately.
- **Receive latency**:
  - `ss_n` falls before edge e0.
  - Edge e0 enters CHK_CMD.
  - Edge e1 samples `c` and enters the data state.
  - Edges e2 through e11 sample the 10 data bits.
  - `rx_data` and `rx_valid` are valid in the cycle after e11. `rx_valid` drops after e12.
- **Transmit latency**:
  - `tx_valid` sampled high at edge k makes `miso=tx_data[7]` after k.
  - `miso=tx_data[0]` after k+7.
  - `miso=0` after k+8, and `rd_addr_done` is cleared at k+8.
- **Minimum frame lengths**:
  - A write or read-address frame is 11 bits.
  - A read-data frame is 11 bits, plus the RAM turnaround, plus 8 transmit cycles.
- **Back-to-back frames**: `ss_n` must be high for at least one edge between frames. IDLE is always passed through.
- **`ss_n` rising at the same edge as bit 0 is sampled**: the word is completed. `rx_valid` is asserted and the FSM then goes to IDLE.

## Test plan
- **Reset**: assert `rst` mid-frame with `ss_n=0`. Outputs must be 0 immediately. After release with `ss_n=0`, CHK_CMD is entered on the next edge.
- **Write address**:
  - Stimulus: `c=0`, then bits 00_0101_0101.
  - Required: `rx_data=10'h055` and a single `rx_valid` pulse in the cycle after the 11th data edge. `rd_addr_done` stays 0.
- **Write data**: `c=0`, then 01_1010_1010 must give `rx_data=10'h1AA`.
- **Read address followed by read data**:
  - Frame 1: `c=1` with 10_0000_0011 must give `rx_data=10'h203` and `rd_addr_done=1`.
  - Frame 2: `c=1` with 11_xxxx_xxxx must give `rx_data[9:8]=11`.
  - Then drive `tx_data=8'hC3`, `tx_valid=1`. MISO must show 1,1,0,0,0,0,1,1 on consecutive cycles, then 0. `rd_addr_done` must return to 0.
- **Abort**: raise `ss_n` after 5 data bits of a read-address frame. There must be no `rx_valid`, the FSM must be in IDLE, and `rd_addr_done` must stay 0. The next full frame must decode correctly.
- **Spurious `tx_valid`**: pulse `tx_valid` during a WRITE frame. `miso` must stay 0.
